// File: rtl/bcd_to_bin_seq.sv
// Packed-BCD to binary converter, reverse double-dabble, one shift per clock.
// Latency ACC_W+1 cycles (1 for invalid digits); result is held in DONE until out_ready.
module bcd_to_bin_seq #(
  parameter int DIGITS = 5,
  parameter int ACC_W  = 17,
  parameter int OUT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      bin_out,
  output logic                  ovf,
  output logic                  err
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(ACC_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [BW-1:0]      bcd_q, bcd_d, bcd_fix;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_sh;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [OUT_W-1:0]   bin_d;
  logic               ovf_d, err_d;
  logic               bad_digit;
  logic [BW+ACC_W-1:0] shifted;
  logic [3:0]         nib;

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE) & ~rst;

  // One reverse double-dabble step: shift right, then undo the x2 carry-in per nibble.
  always_comb begin
    shifted = {bcd_q, acc_q} >> 1;
    acc_sh  = shifted[ACC_W-1:0];
    bcd_fix = shifted[BW+ACC_W-1:ACC_W];
    nib     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = shifted[ACC_W+4*i +: 4];
      bcd_fix[4*i +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    bcd_d     = bcd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    bin_d     = bin_out;
    ovf_d     = ovf;
    err_d     = err;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          bcd_d = bcd_in;
          acc_d = '0;
          cnt_d = '0;
          if (bad_digit) begin
            state_nxt = DONE;
            err_d     = 1'b1;
            bin_d     = '0;
            ovf_d     = 1'b0;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_d = bcd_fix;
        acc_d = acc_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ACC_W - 1)) begin
          state_nxt = DONE;
          err_d     = 1'b0;
          // ACC_W > OUT_W: any set bit above OUT_W means saturation.
          if (|acc_sh[ACC_W-1:OUT_W]) begin
            bin_d = '1;
            ovf_d = 1'b1;
          end else begin
            bin_d = acc_sh[OUT_W-1:0];
            ovf_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_out <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bin_out <= bin_d;
      ovf     <= ovf_d;
      err     <= err_d;
    end
  end

endmodule
